// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags and sticky errors.
// Optional first-word-fall-through read path selected by defining SYNC_FIFO_FWFT_EN.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 1024,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             din,
  input  logic                         we_n,
  input  logic                         oe_n,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;

  // Flags decode the registered count only, so they carry no input-to-output path.
  assign empty        = (count == '0);
  assign full         = (count == CNT_FULL);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  assign rd_acc = !oe_n && !empty;
  assign wr_acc = !we_n && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (rd_acc)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)
        count <= count + 1'b1;
      else if (rd_acc && !wr_acc)
        count <= count - 1'b1;
      if (!we_n && full && !rd_acc)
        overflow <= 1'b1;
      if (!oe_n && empty)
        underflow <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc)
      mem[wr_ptr] <= din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout = empty ? '0 : mem[rd_ptr];
`else
  logic [WIDTH-1:0] dout_q;

  // Registered read; a same-address write in this cycle leaves the old entry on dout.
  always_ff @(posedge clk) begin
    if (!rst_n)
      dout_q <= '0;
    else if (rd_acc)
      dout_q <= mem[rd_ptr];
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (WIDTH=8, DEPTH=6, AF_LEVEL=4, AE_LEVEL=1).
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 6;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             we_n;
  logic             oe_n;
  logic [WIDTH-1:0] dout;
  logic             full, empty, almost_full, almost_empty;
  logic [CW-1:0]    count;
  logic             overflow, underflow;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .we_n(we_n), .oe_n(oe_n), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             m_ovf, m_unf;
  logic [WIDTH-1:0] m_last;
  logic             rd_issued = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted read pops one expected word.
  always @(posedge clk) begin
    if (rd_issued) begin
`ifndef SYNC_FIFO_FWFT_EN
      #1;
`endif
      if (exp_q.size() == 0) begin
        chk("scoreboard_underrun", 1, 0);
      end else begin
        chk("read_data", int'(dout), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_state();
    int n;
    n = mq.size();
    chk("count", int'(count), n);
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == DEPTH));
    chk("almost_full", int'(almost_full), int'(n >= AF));
    chk("almost_empty", int'(almost_empty), int'(n <= AE));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("dout_head", int'(dout), (n == 0) ? 0 : int'(mq[0]));
`else
    chk("dout_hold", int'(dout), int'(m_last));
`endif
  endtask

  task automatic cycle(input logic we, input logic oe, input logic [WIDTH-1:0] d);
    logic rd, wr;
    logic [WIDTH-1:0] v;
    @(negedge clk);
    check_state();
    rst_n = 1'b1;
    we_n  = !we;
    oe_n  = !oe;
    din   = d;
    rd = oe && (mq.size() > 0);
    wr = we && ((mq.size() < DEPTH) || rd);
    if (oe && mq.size() == 0) m_unf = 1'b1;
    if (we && mq.size() == DEPTH && !rd) m_ovf = 1'b1;
    if (rd) begin
      v = mq.pop_front();
      exp_q.push_back(v);
      m_last = v;
    end
    if (wr) mq.push_back(d);
    rd_issued = rd;
  endtask

  task automatic do_reset(input logic we);
    @(negedge clk);
    rst_n = 1'b0;
    we_n  = !we;
    oe_n  = 1'b1;
    din   = 8'hEE;
    rd_issued = 1'b0;
    mq.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_last = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    we_n  = 1'b1;
    oe_n  = 1'b1;
    din   = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_last = '0;

    do_reset(1'b0);
    repeat (3) cycle(1'b0, 1'b0, 8'h00);

    // Fill 0x11..0x16 then drain.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'(8'h11 + i));
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h00);

    // Full: lone write overflows; read+write on full keeps count and queues 0x77 last.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'(8'h21 + i));
    cycle(1'b1, 1'b0, 8'h27);
    cycle(1'b1, 1'b1, 8'h77);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'h00);

    // Empty: lone read underflows; read+write accepts only the write.
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'hA5);
    cycle(1'b0, 1'b1, 8'h00);

    // Pointer wrap with interleaved write/read pairs.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 8'(8'h40 + i));
      cycle(1'b0, 1'b1, 8'h00);
    end

    // Reset with three entries and a write pending discards everything.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h90 + i));
    do_reset(1'b1);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h3C);
    cycle(1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    repeat (2) cycle(1'b0, 1'b0, 8'h00);

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
